// File: rtl/f_25mhz_if.sv
// f_25mhz_if: divided-clock outputs of f_25mhz (CLK and its rising-edge tick).
interface f_25mhz_if;
  logic CLK;
  logic tick;
  modport master (output CLK, tick);
  modport slave (input CLK, tick);
endinterface

// File: rtl/f_25mhz.sv
// f_25mhz: integer clock divider clk -> CLK (DIV even, 50% duty) with a clk-domain rising-edge tick.
// Build macro F25_TICK_EN: when undefined, tick is tied to 0 and its register is not built.
module f_25mhz #(
  parameter int DIV = 4
) (
  input  logic      clk,
  input  logic      reset,
  f_25mhz_if.master bus
);
  localparam int HALF = DIV / 2;
  localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;
  if (DIV < 2 || DIV > 65536 || (DIV % 2) != 0) begin : g_bad_div
    $error("f_25mhz: DIV must be even and in 2..65536");
  end
  logic [CW-1:0] r_cnt;
  logic          r_clk;
  logic          w_wrap;
  assign w_wrap = r_cnt == CW'(HALF - 1);
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
      r_clk <= 1'b0;
    end else begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      r_clk <= w_wrap ? ~r_clk : r_clk;
    end
  end
  assign bus.CLK = r_clk;
`ifdef F25_TICK_EN
  logic r_tick;
  // Registered alongside r_clk so the pulse lands in the cycle CLK first reads 1.
  always_ff @(posedge clk) begin
    if (!reset) r_tick <= 1'b0;
    else        r_tick <= w_wrap & ~r_clk;
  end
  assign bus.tick = r_tick;
`else
  assign bus.tick = 1'b0;
`endif
endmodule

// File: tb/tb_f_25mhz.sv
// tb_f_25mhz: checks f_25mhz at DIV=4, 2 and 10 against an edge-count model of the divider.
module tb_f_25mhz;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;
  int n4 = 0, n2 = 0, n10 = 0;
  always #5 clk = ~clk;
  f_25mhz_if bus4 ();
  f_25mhz_if bus2 ();
  f_25mhz_if bus10 ();
  f_25mhz #(.DIV(4))  dut4  (.clk(clk), .reset(reset), .bus(bus4));
  f_25mhz #(.DIV(2))  dut2  (.clk(clk), .reset(reset), .bus(bus2));
  f_25mhz #(.DIV(10)) dut10 (.clk(clk), .reset(reset), .bus(bus10));
  always @(posedge clk) begin
    n4  <= reset ? n4 + 1 : 0;
    n2  <= reset ? n2 + 1 : 0;
    n10 <= reset ? n10 + 1 : 0;
  end
  function automatic logic exp_clk(int n, int half);
    return ((n / half) % 2) == 1;
  endfunction
  function automatic logic exp_tick(int n, int half);
`ifdef F25_TICK_EN
    return n > 0 && (n % (2 * half)) == half;
`else
    return 1'b0;
`endif
  endfunction
  task automatic test_reset();
    logic [7:0] pat;
    pat = 8'b01100110;
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (bus4.CLK !== 1'b0) begin failures++; $display("FAIL reset_clk got=%b exp=0", bus4.CLK); end
      checks++;
      if (bus4.tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", bus4.tick); end
    end
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (bus4.CLK !== pat[7-i]) begin failures++; $display("FAIL release_clk[%0d] got=%b exp=%b", i, bus4.CLK, pat[7-i]); end
      checks++;
      if (bus4.tick !== exp_tick(i + 1, 2)) begin failures++; $display("FAIL release_tick[%0d] got=%b exp=%b", i, bus4.tick, exp_tick(i + 1, 2)); end
    end
  endtask
  task automatic test_run();
    int rises = 0, ticks = 0, consec = 0, stray = 0, bad_phase = 0, run_len = 0, edges = 0;
    logic prev_clk, prev_tick;
    @(negedge clk);
    prev_clk = bus4.CLK;
    prev_tick = bus4.tick;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      run_len++;
      if (bus4.CLK !== prev_clk) begin
        if (edges > 0 && run_len != 2) bad_phase++;
        edges++;
        run_len = 0;
      end
      if (bus4.CLK && !prev_clk) rises++;
      if (bus4.tick) begin
        ticks++;
        if (prev_tick) consec++;
        if (!(bus4.CLK && !prev_clk)) stray++;
      end
      prev_clk = bus4.CLK;
      prev_tick = bus4.tick;
    end
    checks++;
    if (rises !== 100) begin failures++; $display("FAIL run_rises got=%0d exp=100", rises); end
    checks++;
    if (bad_phase !== 0) begin failures++; $display("FAIL run_phase_len bad=%0d exp=0", bad_phase); end
    checks++;
`ifdef F25_TICK_EN
    if (ticks !== 100) begin failures++; $display("FAIL run_ticks got=%0d exp=100", ticks); end
`else
    if (ticks !== 0) begin failures++; $display("FAIL run_ticks got=%0d exp=0", ticks); end
`endif
    checks++;
    if (consec !== 0) begin failures++; $display("FAIL run_tick_consec got=%0d exp=0", consec); end
    checks++;
    if (stray !== 0) begin failures++; $display("FAIL run_tick_stray got=%0d exp=0", stray); end
  endtask
  task automatic test_mid_reset();
    int budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (n4 % 4 != 2 && budget < 20);
    checks++;
    if (bus4.CLK !== 1'b1) begin failures++; $display("FAIL mid_pre_clk got=%b exp=1 waited=%0d", bus4.CLK, budget); end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus4.CLK !== 1'b0) begin failures++; $display("FAIL mid_reset_clk got=%b exp=0", bus4.CLK); end
    checks++;
    if (bus4.tick !== 1'b0) begin failures++; $display("FAIL mid_reset_tick got=%b exp=0", bus4.tick); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus4.CLK !== 1'b0) begin failures++; $display("FAIL mid_rel_edge1 got=%b exp=0", bus4.CLK); end
    @(negedge clk);
    checks++;
    if (bus4.CLK !== 1'b1) begin failures++; $display("FAIL mid_rel_edge2 got=%b exp=1", bus4.CLK); end
  endtask
  task automatic test_div2_div10();
    int r2 = 0, r10 = 0, hi10 = 0, lo10 = 0;
    logic p2, p10;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    p2 = bus2.CLK;
    p10 = bus10.CLK;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if (bus2.CLK === p2) begin failures++; $display("FAIL div2_toggle[%0d] got=%b prev=%b", i, bus2.CLK, p2); end
      if (bus2.CLK && !p2) r2++;
      if (bus10.CLK && !p10) r10++;
      if (bus10.CLK) hi10++; else lo10++;
      p2 = bus2.CLK;
      p10 = bus10.CLK;
    end
    checks++;
    if (r2 !== 20) begin failures++; $display("FAIL div2_rises got=%0d exp=20", r2); end
    checks++;
    if (r10 !== 4) begin failures++; $display("FAIL div10_rises got=%0d exp=4", r10); end
    checks++;
    if (hi10 !== 20 || lo10 !== 20) begin failures++; $display("FAIL div10_duty hi=%0d lo=%0d exp=20/20", hi10, lo10); end
  endtask
  task automatic test_random();
    int hold = 0;
    for (int i = 0; i < 2000; i++) begin
      if (hold > 0) hold--;
      else if ($urandom_range(49) == 0) hold = $urandom_range(4, 1);
      reset = (hold == 0);
      @(negedge clk);
      checks++;
      if (bus4.CLK !== exp_clk(n4, 2) || bus4.tick !== exp_tick(n4, 2)) begin
        failures++; $display("FAIL rand_div4[%0d] clk=%b tick=%b exp=%b/%b", i, bus4.CLK, bus4.tick, exp_clk(n4, 2), exp_tick(n4, 2));
      end
      checks++;
      if (bus2.CLK !== exp_clk(n2, 1) || bus2.tick !== exp_tick(n2, 1)) begin
        failures++; $display("FAIL rand_div2[%0d] clk=%b tick=%b exp=%b/%b", i, bus2.CLK, bus2.tick, exp_clk(n2, 1), exp_tick(n2, 1));
      end
      checks++;
      if (bus10.CLK !== exp_clk(n10, 5) || bus10.tick !== exp_tick(n10, 5)) begin
        failures++; $display("FAIL rand_div10[%0d] clk=%b tick=%b exp=%b/%b", i, bus10.CLK, bus10.tick, exp_clk(n10, 5), exp_tick(n10, 5));
      end
    end
  endtask
  initial begin
    reset = 1'b0;
    test_reset();
    test_run();
    test_mid_reset();
    test_div2_div10();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
